board_renderer: RTL and testbench
=================================

BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter COLS, default 7: board columns.
REQ-002 Parameter ROWS, default 6: board rows.
REQ-003 Parameter CELL_SIZE, default 80: cell edge in pixels.
REQ-004 Parameter LEFT_MARGIN, default 40; TOP_MARGIN, default 0: board origin in pixels.
REQ-005 Parameter BLINK_FRAMES, default 30: frames per winner-blink half-period.
REQ-006 Parameter DROP_FRAMES, default 4: frames per row step of the falling-token animation.
REQ-007 Ports, one per line (CW = $clog2(COLS), RW = $clog2(ROWS)):
 clk  in  1  pixel-domain clock
 rst  in  1  asynchronous, active-high reset
 blank_b  in  1  high in the visible area
 x, y  in  10 each  current pixel coordinate
 frame_start  in  1  one-cycle pulse once per frame
 board_state  in  2*ROWS*COLS  2 bits per cell, index (row*COLS+col)*2; 01=P1, 10=P2, else empty
 winner_play  in  ROWS*COLS  1 = cell belongs to the winning line
 theres_a_winner  in  1  winner valid
 cursor_en  in  1  show the selection cursor
 cursor_col  in  CW  selected column
 cursor_player  in  2  player whose turn it is
 drop_valid  in  1  request a drop animation
 drop_ready  out  1  animator idle
 drop_col  in  CW; drop_row  in  RW; drop_player  in  2  drop target and owner
 drop_done  out  1  one-cycle pulse at animation end
 r, g, b  out  8 each  pixel colour
 blank_b_o  out  1  blank_b delayed to align with r/g/b

Function
REQ-008 The pixel path SHALL be a 2-stage pipeline: x/y/blank_b in cycle N produce r/g/b/blank_b_o in cycle N+2, with no stalls.
REQ-009 Stage 1 SHALL register in_board, col = (x-LEFT_MARGIN)/CELL_SIZE and row = (y-TOP_MARGIN)/CELL_SIZE, where in_board = blank_b and the pixel lies in [LEFT_MARGIN, LEFT_MARGIN+COLS*CELL_SIZE) x [TOP_MARGIN, TOP_MARGIN+ROWS*CELL_SIZE).
REQ-010 Stage 2 SHALL select the colour by priority: (a) !in_board -> 000000; (b) theres_a_winner, winner bit set, blink_on -> FFFFFF; (c) animating, col==drop_col, row==anim_row -> drop_player colour; (d) animating, col==drop_col, row==drop_row -> treated as empty; (e) cell 01 -> FF0000, 10 -> 0000FF; (f) cursor_en, col==cursor_col, cell empty -> 400000 if cursor_player==01, 000040 if 10; (g) otherwise 000000.
REQ-011 A winning cell with blink_on low SHALL show its normal colour per (c)-(g).
REQ-012 Blink: while theres_a_winner is low, blink_cnt=0 and blink_on=1; while high, each frame_start increments blink_cnt, and at BLINK_FRAMES-1 blink_cnt wraps to 0 and blink_on toggles.
REQ-013 Animator FSM states IDLE, FALL, DONE; drop_ready=1 only in IDLE.
REQ-014 IDLE: on drop_valid, capture drop_col/drop_row/drop_player (drop_row > ROWS-1 clamped to ROWS-1), set anim_row=0 and frame_cnt=0, go to FALL.
REQ-015 FALL: each frame_start increments frame_cnt; at DROP_FRAMES-1, frame_cnt=0, then DONE if anim_row==captured row, else anim_row+1.
REQ-016 DONE: drop_done=1 for exactly one cycle, then IDLE; drop_valid outside IDLE SHALL be ignored.
REQ-017 frame_start coincident with drop_valid in IDLE SHALL NOT count toward the first step.
REQ-018 Captured drop fields SHALL stay stable in FALL/DONE regardless of input changes.

Reset
REQ-019 rst high SHALL asynchronously force: FSM=IDLE, drop_ready=1, drop_done=0, anim_row=0, frame_cnt=0, blink_cnt=0, blink_on=1, all pipeline registers 0, and thus r=g=b=0 and blank_b_o=0.
REQ-020 Reset during FALL SHALL abandon the animation without a drop_done pulse.

Structure
REQ-021 Package board_pkg SHALL hold the cell-code constants (EMPTY, P1, P2), the 24-bit colour constants and the animator state enum.
REQ-022 The animator FSM SHALL be a sub-module, drop_animator; blink logic and the pixel pipeline stay in board_renderer.

Verification
REQ-023 Defaults: cell (0,0)=01, pixel (40,0) blank_b=1 -> r/g/b=FF/00/00 two cycles later; pixel (39,0) -> 000000.
REQ-024 Winner on cell (5,3), theres_a_winner=1, 60 frame_start pulses -> cell colour alternates white / player colour every 30 frames, starting white.
REQ-025 drop col=2, row=5, player=10 -> blue token at rows 0..5, one row per 4 frames; drop_done pulses once after 24 frames; drop_ready=0 throughout.
REQ-026 cursor_en=1, cursor_col=6, cursor_player=01, column 6 empty except row 5 = 10 -> rows 0-4 show 400000, row 5 shows 0000FF.
REQ-027 rst asserted at frame 10 of a drop -> outputs 0 immediately, drop_ready=1, no drop_done; a new drop then completes normally.
REQ-028 drop_row=7 -> animation ends at row 5 with drop_done after 24 frames.

Source files
------------

// File: rtl/board_pkg.sv
// Shared cell codes, colours and animator state encoding for the board renderer.
package board_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [23:0] COLOR_BLACK  = 24'h000000;
    localparam logic [23:0] COLOR_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] COLOR_P1     = 24'hFF0000;
    localparam logic [23:0] COLOR_P2     = 24'h0000FF;
    localparam logic [23:0] COLOR_CUR_P1 = 24'h400000;
    localparam logic [23:0] COLOR_CUR_P2 = 24'h000040;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_DONE = 2'd2
    } anim_state_t;

    function automatic logic [23:0] player_color(input logic [1:0] code);
        logic [23:0] c;
        c = COLOR_BLACK;
        if (code == P1) c = COLOR_P1;
        else if (code == P2) c = COLOR_P2;
        return c;
    endfunction

    function automatic logic [23:0] cursor_color(input logic [1:0] code);
        logic [23:0] c;
        c = COLOR_BLACK;
        if (code == P1) c = COLOR_CUR_P1;
        else if (code == P2) c = COLOR_CUR_P2;
        return c;
    endfunction

endpackage

// File: rtl/board_renderer_drop_animator.sv
// Falling-token animator: steps a token down one row every DROP_FRAMES frames.
module drop_animator
    import board_pkg::*;
#(
    parameter int ROWS        = 6,
    parameter int DROP_FRAMES = 4,
    parameter int CW          = 3,
    parameter int RW          = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start_i,
    input  logic          drop_valid_i,
    input  logic [CW-1:0] drop_col_i,
    input  logic [RW-1:0] drop_row_i,
    input  logic [1:0]    drop_player_i,
    output logic          drop_ready_o,
    output logic          drop_done_o,
    output logic          active_o,
    output logic [RW-1:0] anim_row_o,
    output logic [CW-1:0] cap_col_o,
    output logic [RW-1:0] cap_row_o,
    output logic [1:0]    cap_player_o
);

    localparam int FW = (DROP_FRAMES > 1) ? $clog2(DROP_FRAMES) : 1;
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(DROP_FRAMES - 1);

    anim_state_t   state_q;
    logic          ready_q;
    logic          done_q;
    logic          active_q;
    logic [RW-1:0] anim_row_q;
    logic [FW-1:0] frame_cnt_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [1:0]    player_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            active_q    <= 1'b0;
            anim_row_q  <= '0;
            frame_cnt_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            player_q    <= EMPTY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A frame_start in the capture cycle is deliberately not counted.
                    if (drop_valid_i) begin
                        col_q       <= drop_col_i;
                        row_q       <= (drop_row_i > LAST_ROW) ? LAST_ROW : drop_row_i;
                        player_q    <= drop_player_i;
                        anim_row_q  <= '0;
                        frame_cnt_q <= '0;
                        ready_q     <= 1'b0;
                        active_q    <= 1'b1;
                        state_q     <= ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (frame_start_i) begin
                        if (frame_cnt_q == LAST_FRAME) begin
                            frame_cnt_q <= '0;
                            if (anim_row_q == row_q) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                anim_row_q <= anim_row_q + 1'b1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    done_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign drop_ready_o = ready_q;
    assign drop_done_o  = done_q;
    assign active_o     = active_q;
    assign anim_row_o   = anim_row_q;
    assign cap_col_o    = col_q;
    assign cap_row_o    = row_q;
    assign cap_player_o = player_q;

endmodule

// File: rtl/board_renderer.sv
// Two-stage pixel pipeline drawing the game board, winner blink, cursor and drop animation.
module board_renderer
    import board_pkg::*;
#(
    parameter int COLS         = 7,
    parameter int ROWS         = 6,
    parameter int CELL_SIZE    = 80,
    parameter int LEFT_MARGIN  = 40,
    parameter int TOP_MARGIN   = 0,
    parameter int BLINK_FRAMES = 30,
    parameter int DROP_FRAMES  = 4,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blank_b,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   frame_start,
    input  logic [2*ROWS*COLS-1:0] board_state,
    input  logic [ROWS*COLS-1:0]   winner_play,
    input  logic                   theres_a_winner,
    input  logic                   cursor_en,
    input  logic [CW-1:0]          cursor_col,
    input  logic [1:0]             cursor_player,
    input  logic                   drop_valid,
    output logic                   drop_ready,
    input  logic [CW-1:0]          drop_col,
    input  logic [RW-1:0]          drop_row,
    input  logic [1:0]             drop_player,
    output logic                   drop_done,
    output logic [7:0]             r,
    output logic [7:0]             g,
    output logic [7:0]             b,
    output logic                   blank_b_o
);

    localparam int NCELLS = ROWS * COLS;
    localparam int IW     = $clog2(NCELLS);
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Blink generator
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (!theres_a_winner) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Drop animator
    logic          anim_active;
    logic [RW-1:0] anim_row;
    logic [CW-1:0] anim_col;
    logic [RW-1:0] anim_target_row;
    logic [1:0]    anim_player;

    drop_animator #(
        .ROWS        (ROWS),
        .DROP_FRAMES (DROP_FRAMES),
        .CW          (CW),
        .RW          (RW)
    ) u_drop_animator (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .drop_valid_i  (drop_valid),
        .drop_col_i    (drop_col),
        .drop_row_i    (drop_row),
        .drop_player_i (drop_player),
        .drop_ready_o  (drop_ready),
        .drop_done_o   (drop_done),
        .active_o      (anim_active),
        .anim_row_o    (anim_row),
        .cap_col_o     (anim_col),
        .cap_row_o     (anim_target_row),
        .cap_player_o  (anim_player)
    );

    // Stage 1: locate the pixel on the board grid
    int            x_rel, y_rel;
    logic          in_board_d, in_board_q;
    logic [CW-1:0] col_d, col_q;
    logic [RW-1:0] row_d, row_q;
    logic          blank1_q;

    always_comb begin
        x_rel      = int'(x) - LEFT_MARGIN;
        y_rel      = int'(y) - TOP_MARGIN;
        in_board_d = blank_b
                     && (x_rel >= 0) && (x_rel < COLS * CELL_SIZE)
                     && (y_rel >= 0) && (y_rel < ROWS * CELL_SIZE);
        col_d = '0;
        row_d = '0;
        // Off-board pixels park at cell 0 so the stage-2 cell index stays in range.
        if (in_board_d) begin
            col_d = CW'(x_rel / CELL_SIZE);
            row_d = RW'(y_rel / CELL_SIZE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_board_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            blank1_q   <= 1'b0;
        end else begin
            in_board_q <= in_board_d;
            col_q      <= col_d;
            row_q      <= row_d;
            blank1_q   <= blank_b;
        end
    end

    // Stage 2: colour selection
    logic [1:0] cell_arr [NCELLS];

    genvar gi;
    generate
        for (gi = 0; gi < NCELLS; gi++) begin : g_cells
            assign cell_arr[gi] = board_state[2*gi +: 2];
        end
    endgenerate

    logic [IW-1:0] idx;
    logic [1:0]    eff_code;
    logic          on_drop_col;
    logic [23:0]   rgb_d, rgb_q;
    logic          blank2_q;

    assign idx = IW'(row_q) * IW'(COLS) + IW'(col_q);

    always_comb begin
        eff_code    = cell_arr[idx];
        on_drop_col = anim_active && (col_q == anim_col);
        rgb_d       = COLOR_BLACK;
        if (!in_board_q) begin
            rgb_d = COLOR_BLACK;
        end else if (theres_a_winner && winner_play[idx] && blink_on_q) begin
            rgb_d = COLOR_WHITE;
        end else if (on_drop_col && (row_q == anim_row)) begin
            rgb_d = player_color(anim_player);
        end else begin
            // Hide the landing cell until the token reaches it.
            if (on_drop_col && (row_q == anim_target_row)) eff_code = EMPTY;
            if (eff_code == P1 || eff_code == P2) begin
                rgb_d = player_color(eff_code);
            end else if (cursor_en && (col_q == cursor_col)) begin
                rgb_d = cursor_color(cursor_player);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q    <= COLOR_BLACK;
            blank2_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            blank2_q <= blank1_q;
        end
    end

    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];
    assign blank_b_o = blank2_q;

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: directed pixels, blink, cursor and drop scenarios.
module tb_board_renderer;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        blank_b;
    logic [9:0]  x, y;
    logic        frame_start;
    logic [2*ROWS*COLS-1:0] board_state;
    logic [ROWS*COLS-1:0]   winner_play;
    logic        theres_a_winner;
    logic        cursor_en;
    logic [2:0]  cursor_col;
    logic [1:0]  cursor_player;
    logic        drop_valid;
    logic        drop_ready;
    logic [2:0]  drop_col;
    logic [2:0]  drop_row;
    logic [1:0]  drop_player;
    logic        drop_done;
    logic [7:0]  r, g, b;
    logic        blank_b_o;

    always #5 clk = ~clk;

    board_renderer dut (
        .clk             (clk),
        .rst             (rst),
        .blank_b         (blank_b),
        .x               (x),
        .y               (y),
        .frame_start     (frame_start),
        .board_state     (board_state),
        .winner_play     (winner_play),
        .theres_a_winner (theres_a_winner),
        .cursor_en       (cursor_en),
        .cursor_col      (cursor_col),
        .cursor_player   (cursor_player),
        .drop_valid      (drop_valid),
        .drop_ready      (drop_ready),
        .drop_col        (drop_col),
        .drop_row        (drop_row),
        .drop_player     (drop_player),
        .drop_done       (drop_done),
        .r               (r),
        .g               (g),
        .b               (b),
        .blank_b_o       (blank_b_o)
    );

    typedef struct {
        string       name;
        logic [24:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    logic issue = 1'b0, v1 = 1'b0, v2 = 1'b0;

    // Two-cycle marker delay tells the monitor when an issued pixel reaches the output.
    always @(posedge clk) begin
        v1 <= issue;
        v2 <= v1;
    end

    always @(negedge clk) begin
        if (drop_done) done_cnt++;
        if (v2) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got %h required nothing", {blank_b_o, r, g, b});
            end else begin
                mon_e = sb_q.pop_front();
                if ({blank_b_o, r, g, b} !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", mon_e.name, {blank_b_o, r, g, b}, mon_e.exp);
                end else begin
                    $display("ok   %s: %h", mon_e.name, mon_e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic int cx(input int c);
        return 40 + 80 * c + 40;
    endfunction

    function automatic int cy(input int rr);
        return 80 * rr + 40;
    endfunction

    task automatic set_cell(input int c, input int rr, input logic [1:0] code);
        board_state[(rr*COLS + c)*2 +: 2] = code;
    endtask

    task automatic px(input string name, input int xi, input int yi, input logic bl, input logic [23:0] e);
        exp_t t;
        x       = 10'(xi);
        y       = 10'(yi);
        blank_b = bl;
        issue   = 1'b1;
        t.name  = name;
        t.exp   = {bl, e};
        sb_q.push_back(t);
        @(posedge clk); #1;
    endtask

    task automatic flush();
        issue   = 1'b0;
        blank_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_drop(input logic [2:0] c, input logic [2:0] rr, input logic [1:0] p, input logic with_frame);
        drop_col    = c;
        drop_row    = rr;
        drop_player = p;
        drop_valid  = 1'b1;
        frame_start = with_frame;
        @(posedge clk); #1;
        drop_valid  = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        blank_b = 1'b1; x = 10'd40; y = 10'd0; frame_start = 1'b0;
        board_state = '0; winner_play = '0; theres_a_winner = 1'b0;
        cursor_en = 1'b0; cursor_col = '0; cursor_player = 2'b00;
        drop_valid = 1'b0; drop_col = '0; drop_row = '0; drop_player = 2'b00;
        set_cell(0, 0, 2'b01);
        repeat (4) @(posedge clk);
        #1;
        chk("reset_rgb", {8'h0, r, g, b}, 32'h0);
        chk("reset_blank_o", {31'h0, blank_b_o}, 32'h0);
        chk("reset_ready", {31'h0, drop_ready}, 32'h1);
        chk("reset_done", {31'h0, drop_done}, 32'h0);
        rst = 1'b0;
        blank_b = 1'b0;
        @(posedge clk); #1;

        // Basic cell colours and board boundaries
        set_cell(6, 5, 2'b10);
        px("def_left_edge", 40, 0, 1'b1, 24'hFF0000);
        px("def_left_out", 39, 0, 1'b1, 24'h000000);
        px("def_blanked", 40, 0, 1'b0, 24'h000000);
        px("def_empty", cx(1), cy(0), 1'b1, 24'h000000);
        px("def_bottom_right", 599, 479, 1'b1, 24'h0000FF);
        px("def_right_out", 600, 10, 1'b1, 24'h000000);
        px("def_bottom_out", 45, 480, 1'b1, 24'h000000);
        flush();

        // Cursor column
        cursor_en = 1'b1; cursor_col = 3'd6; cursor_player = 2'b01;
        for (int rr = 0; rr < 5; rr++) px($sformatf("cursor_p1_row%0d", rr), cx(6), cy(rr), 1'b1, 24'h400000);
        px("cursor_occupied", cx(6), cy(5), 1'b1, 24'h0000FF);
        px("cursor_other_col", cx(5), cy(0), 1'b1, 24'h000000);
        flush();
        cursor_player = 2'b10;
        px("cursor_p2", cx(6), cy(2), 1'b1, 24'h000040);
        flush();
        cursor_en = 1'b0;

        // Winner blink on cell (5,3)
        set_cell(5, 3, 2'b01);
        winner_play[3*COLS + 5] = 1'b1;
        theres_a_winner = 1'b1;
        @(posedge clk); #1;
        px("blink_start", cx(5), cy(3), 1'b1, 24'hFFFFFF);
        px("blink_nonwin", cx(0), cy(0), 1'b1, 24'hFF0000);
        flush();
        repeat (29) frame();
        px("blink_f29", cx(5), cy(3), 1'b1, 24'hFFFFFF);
        flush();
        frame();
        px("blink_f30", cx(5), cy(3), 1'b1, 24'hFF0000);
        flush();
        repeat (29) frame();
        px("blink_f59", cx(5), cy(3), 1'b1, 24'hFF0000);
        flush();
        frame();
        px("blink_f60", cx(5), cy(3), 1'b1, 24'hFFFFFF);
        flush();
        repeat (30) frame();
        theres_a_winner = 1'b0;
        @(posedge clk); #1;
        px("blink_nowinner", cx(5), cy(3), 1'b1, 24'hFF0000);
        flush();
        theres_a_winner = 1'b1;
        @(posedge clk); #1;
        px("blink_rearm", cx(5), cy(3), 1'b1, 24'hFFFFFF);
        flush();
        theres_a_winner = 1'b0;
        winner_play = '0;
        board_state = '0;

        // Drop into column 2, row 5, player 2; target cell already written
        set_cell(2, 5, 2'b10);
        start_drop(3'd2, 3'd5, 2'b10, 1'b1);
        drop_col = 3'd4; drop_row = 3'd0; drop_player = 2'b01;
        chk("drop_ready_low", {31'h0, drop_ready}, 32'h0);
        px("drop_s0_token", cx(2), cy(0), 1'b1, 24'h0000FF);
        px("drop_s0_target_hidden", cx(2), cy(5), 1'b1, 24'h000000);
        px("drop_s0_below", cx(2), cy(1), 1'b1, 24'h000000);
        flush();
        for (int s = 1; s <= 5; s++) begin
            if (s == 2) begin
                drop_valid = 1'b1;
                @(posedge clk); #1;
                drop_valid = 1'b0;
            end
            repeat (4) frame();
            px($sformatf("drop_s%0d_token", s), cx(2), cy(s), 1'b1, 24'h0000FF);
            px($sformatf("drop_s%0d_above", s), cx(2), cy(s - 1), 1'b1, 24'h000000);
            flush();
            chk($sformatf("drop_s%0d_ready", s), {31'h0, drop_ready}, 32'h0);
        end
        repeat (3) frame();
        chk("drop_no_early_done", done_cnt, 0);
        chk("drop_ready_f23", {31'h0, drop_ready}, 32'h0);
        frame();
        repeat (3) @(posedge clk);
        #1;
        chk("drop_done_once", done_cnt, 1);
        chk("drop_ready_back", {31'h0, drop_ready}, 32'h1);
        px("post_drop_board", cx(2), cy(5), 1'b1, 24'h0000FF);
        px("post_drop_top", cx(2), cy(0), 1'b1, 24'h000000);
        flush();
        board_state = '0;

        // Reset in the middle of a drop
        start_drop(3'd0, 3'd5, 2'b01, 1'b0);
        repeat (10) frame();
        x = 10'(cx(0)); y = 10'(cy(2)); blank_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_token", {8'h0, r, g, b}, 32'h00FF0000);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rgb", {8'h0, r, g, b}, 32'h0);
        chk("midrst_blank_o", {31'h0, blank_b_o}, 32'h0);
        chk("midrst_ready", {31'h0, drop_ready}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        blank_b = 1'b0;
        repeat (5) frame();
        chk("midrst_no_done", done_cnt, 1);

        // New drop with an out-of-range row lands on the bottom row
        start_drop(3'd3, 3'd7, 2'b01, 1'b0);
        repeat (23) frame();
        px("clamp_row5_token", cx(3), cy(5), 1'b1, 24'hFF0000);
        px("clamp_row4_clear", cx(3), cy(4), 1'b1, 24'h000000);
        flush();
        chk("clamp_no_early_done", done_cnt, 1);
        frame();
        repeat (3) @(posedge clk);
        #1;
        chk("clamp_done", done_cnt, 2);
        chk("clamp_ready", {31'h0, drop_ready}, 32'h1);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
